// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types and helpers for the RAM round-robin arbiter and related arbiters.
package ram_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searched circularly from last+1.
module rr_pick
  import ram_rr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_last,
  output logic [NREQ-1:0] o_winner_oh,
  output logic [OW-1:0]   o_winner_idx,
  output logic            o_any
);

  localparam int SW = OW + 1;

  logic [OW-1:0]     w_start;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [OW-1:0]     w_low_idx;
  logic [SW-1:0]     w_sum;

  assign w_start = (i_last == OW'(NREQ - 1)) ? '0 : i_last + 1'b1;

  // Rotating right by the start index puts the highest-priority requester at bit 0.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[w_start +: NREQ];

  always_comb begin
    w_low_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_low_idx = OW'(k);
    end
  end

  assign w_sum        = {1'b0, w_low_idx} + {1'b0, w_start};
  assign o_winner_idx = (w_sum >= SW'(NREQ)) ? OW'(w_sum - SW'(NREQ)) : OW'(w_sum);
  assign o_any        = |i_req;
  assign o_winner_oh  = o_any ? (NREQ'(1) << o_winner_idx) : '0;

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NREQ requesters,
// with bursts of up to MAX_BURST accesses per grant and per-requester read return.
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               ram_en,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_rdata
);

  localparam int OW = idx_width(NREQ);
  localparam int CW = idx_width(MAX_BURST + 1);

  arb_state_e      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [OW-1:0]   r_owner;
  logic [CW-1:0]   r_burst_cnt;
  logic [OW-1:0]   r_last;
  logic [NREQ-1:0] r_rvalid;

  logic [NREQ-1:0] w_pick_oh;
  logic [OW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic [AW-1:0]   w_addr_arr  [NREQ];
  logic [DW-1:0]   w_wdata_arr [NREQ];
  logic            w_own_req;
  logic            w_own_we;
  logic            w_access;
  logic            w_burst_done;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = addr[gi*AW +: AW];
      assign w_wdata_arr[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .i_req        (req),
    .i_last       (r_last),
    .o_winner_oh  (w_pick_oh),
    .o_winner_idx (w_pick_idx),
    .o_any        (w_pick_any)
  );

  assign w_own_req    = req[r_owner];
  assign w_own_we     = we[r_owner];
  assign w_access     = (r_state == BUSY) && w_own_req;
  assign w_burst_done = (r_burst_cnt == CW'(MAX_BURST - 1));

  // RAM strobes derive from state so an async reset kills them without waiting for an edge.
  assign ram_en    = w_access;
  assign ram_we    = w_access & w_own_we;
  assign ram_addr  = w_addr_arr[r_owner];
  assign ram_wdata = w_wdata_arr[r_owner];
  assign ack       = w_access ? r_gnt : '0;
  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = (|r_rvalid) ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_last      <= OW'(NREQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_gnt       <= w_pick_oh;
            r_owner     <= w_pick_idx;
            r_burst_cnt <= '0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (w_access) r_burst_cnt <= r_burst_cnt + 1'b1;
          if (!w_own_req || w_burst_done) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read return runs beside the FSM so it completes across a release or a new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= '0;
    end else begin
      r_rvalid <= (w_access && !w_own_we) ? r_gnt : '0;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a holder/queue-level reference model.
module tb_ram_rr_arbiter;

  localparam int NREQ      = 4;
  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt, ack, rvalid;
  logic [DW-1:0]     rdata;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata = '0;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_holder;
  int          m_count;
  int          m_last;
  bit          m_pend_valid;
  int          m_pend_req;
  logic [7:0]  m_pend_data;
  logic [7:0]  shadow [256];
  logic [7:0]  mem    [256];

  always #5 clk = ~clk;

  ram_rr_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_holder     = -1;
    m_count      = 0;
    m_last       = NREQ - 1;
    m_pend_valid = 0;
  endtask

  task automatic check_model();
    logic [NREQ-1:0] e_gnt, e_ack, e_rv;
    bit e_en, e_we;
    e_gnt = '0; e_en = 0; e_we = 0;
    if (m_holder >= 0) begin
      e_gnt = NREQ'(1) << m_holder;
      e_en  = req[m_holder];
      e_we  = e_en && we[m_holder];
    end
    e_ack = e_en ? e_gnt : '0;
    e_rv  = m_pend_valid ? (NREQ'(1) << m_pend_req) : '0;
    cmp("gnt", 32'(gnt), 32'(e_gnt));
    cmp("ack", 32'(ack), 32'(e_ack));
    cmp("ram_en", 32'(ram_en), 32'(e_en));
    cmp("ram_we", 32'(ram_we), 32'(e_we));
    cmp("rvalid", 32'(rvalid), 32'(e_rv));
    if (m_pend_valid) cmp("rdata", 32'(rdata), 32'(m_pend_data));
    if (e_en) cmp("ram_addr", 32'(ram_addr), 32'(addr[m_holder*AW +: AW]));
    if (e_we) cmp("ram_wdata", 32'(ram_wdata), 32'(wdata[m_holder*DW +: DW]));
  endtask

  task automatic update_model();
    logic [7:0] a;
    if (rst) begin
      model_reset();
      return;
    end
    m_pend_valid = 0;
    if (m_holder < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_last + 1 + k) % NREQ;
        if (req[j]) begin
          m_holder = j;
          m_count  = 0;
          break;
        end
      end
    end else if (req[m_holder]) begin
      a = addr[m_holder*AW +: AW];
      if (we[m_holder]) begin
        shadow[a] = wdata[m_holder*DW +: DW];
      end else begin
        m_pend_valid = 1;
        m_pend_req   = m_holder;
        m_pend_data  = shadow[a];
      end
      m_count++;
      if (m_count == MAX_BURST) begin
        m_last   = m_holder;
        m_holder = -1;
      end
    end else begin
      m_last   = m_holder;
      m_holder = -1;
    end
  endtask

  // Observe one cycle (away from the edge), then advance past the next edge.
  task automatic cyc();
    @(negedge clk);
    check_model();
  endtask

  task automatic adv();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drain(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      cyc();
      adv();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    model_reset();
    rst   = 1'b1;
    req   = 4'b1111;
    we    = '0;
    addr  = '0;
    wdata = '0;

    // Reset with all requests held
    for (int i = 0; i < 2; i++) begin
      cyc();
      cmp("rst_gnt", 32'(gnt), 32'h0);
      cmp("rst_ram_en", 32'(ram_en), 32'h0);
      cmp("rst_rvalid", 32'(rvalid), 32'h0);
      adv();
    end
    rst = 1'b0;
    cyc();
    cmp("first_idle_gnt", 32'(gnt), 32'h0);
    adv();

    // Full contention: 4 accesses per owner, 5-cycle period, owners 0,1,2,3,0
    for (int c = 0; c < 25; c++) begin
      logic [NREQ-1:0] e;
      e = ((c % 5) < 4) ? (NREQ'(1) << ((c / 5) % 4)) : '0;
      cyc();
      cmp("contend_gnt", 32'(gnt), 32'(e));
      cmp("contend_ack", 32'(ack), 32'(e));
      adv();
    end
    drain(4);

    // Single write then read by requester 1
    req = 4'b0010; we = 4'b0010;
    addr[1*AW +: AW] = 8'h10; wdata[1*DW +: DW] = 8'hA5;
    cyc(); adv();
    cyc();
    cmp("wr_gnt", 32'(gnt), 32'h2);
    cmp("wr_ram_we", 32'(ram_we), 32'h1);
    cmp("wr_ram_addr", 32'(ram_addr), 32'h10);
    cmp("wr_ack", 32'(ack), 32'h2);
    adv();
    req = '0;
    cyc(); adv();
    cyc(); adv();
    req = 4'b0010; we = '0;
    cyc(); adv();
    cyc();
    cmp("rd_ack", 32'(ack), 32'h2);
    cmp("rd_ram_we", 32'(ram_we), 32'h0);
    adv();
    req = '0;
    cyc();
    cmp("rd_rvalid", 32'(rvalid), 32'h2);
    cmp("rd_rdata", 32'(rdata), 32'hA5);
    adv();
    drain(3);

    // No preemption: requester 2 bursts, requester 0 rises mid-burst
    req = 4'b0100;
    cyc(); adv();
    for (int k = 0; k < 4; k++) begin
      cyc();
      cmp("nopre_gnt", 32'(gnt), 32'h4);
      adv();
      if (k == 0) req = 4'b0101;
    end
    cyc();
    cmp("nopre_gap", 32'(gnt), 32'h0);
    adv();
    cyc();
    cmp("nopre_next", 32'(gnt), 32'h1);
    adv();
    drain(4);

    // Early drop: owner 1 releases after 2 accesses, rotation picks 3 over 0
    req = 4'b1011;
    cyc(); adv();
    cyc();
    cmp("drop_gnt", 32'(gnt), 32'h2);
    cmp("drop_ack1", 32'(ack), 32'h2);
    adv();
    cyc();
    cmp("drop_ack2", 32'(ack), 32'h2);
    adv();
    req = 4'b1001;
    cyc();
    cmp("drop_noack", 32'(ack), 32'h0);
    adv();
    cyc();
    cmp("drop_gap", 32'(gnt), 32'h0);
    adv();
    cyc();
    cmp("drop_next", 32'(gnt), 32'h8);
    adv();
    drain(4);

    // Async reset with a read outstanding
    req = 4'b0001; we = '0; addr[0 +: AW] = 8'h10;
    cyc(); adv();
    cyc();
    cmp("arst_ack", 32'(ack), 32'h1);
    adv();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp("arst_gnt", 32'(gnt), 32'h0);
    cmp("arst_ram_en", 32'(ram_en), 32'h0);
    cmp("arst_rvalid", 32'(rvalid), 32'h0);
    req = 4'b1001;
    @(posedge clk);
    update_model();
    #1;
    rst = 1'b0;
    cyc();
    cmp("arst_no_rvalid", 32'(rvalid), 32'h0);
    adv();
    cyc();
    cmp("arst_winner", 32'(gnt), 32'h1);
    adv();
    drain(6);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if ($urandom_range(5) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          req[i] = 1'b1;
        end
        we[i] = 1'($urandom_range(1));
        addr[i*AW +: AW]  = 8'($urandom_range(15));
        wdata[i*DW +: DW] = 8'($urandom);
      end
      cyc();
      adv();
    end
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
